// File: rtl/regwr_sched.sv
// Two-requester register-file write scheduler with round-robin arbitration
// and a 31-cycle sequence that zeroes registers 1..31.
module regwr_sched #(
    parameter int   DW        = 32,
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic          ck,
    input  logic          reset,
    input  logic          clr_req,
    input  logic          req0_valid,
    input  logic [4:0]    req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [4:0]    req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic [4:0]    wa,
    output logic [DW-1:0] wdata,
    output logic          we,
    output logic          grant_id,
    output logic          clr_busy
);

    typedef enum logic {RUN, CLEAR} state_t;

    state_t        state;
    logic [4:0]    cnt;
    logic          prio;
    logic          xfer0;
    logic          xfer1;
    logic [4:0]    sel_addr;
    logic [DW-1:0] sel_data;

    // Clear requests win over both requesters; prio only matters when both are valid.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (reset && state == RUN && !clr_req) begin
            if (req0_valid && (!req1_valid || !prio))
                req0_ready = 1'b1;
            else if (req1_valid)
                req1_ready = 1'b1;
        end
    end

    always_comb begin
        xfer0    = req0_valid && req0_ready;
        xfer1    = req1_valid && req1_ready;
        sel_addr = xfer1 ? req1_addr : req0_addr;
        sel_data = xfer1 ? req1_data : req0_data;
    end

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            cnt      <= 5'd1;
            prio     <= PRIO_INIT;
            wa       <= '0;
            wdata    <= '0;
            we       <= 1'b0;
            grant_id <= 1'b0;
            clr_busy <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (clr_req) begin
                        state    <= CLEAR;
                        cnt      <= 5'd1;
                        clr_busy <= 1'b1;
                        we       <= 1'b0;
                    end else if (xfer0 || xfer1) begin
                        wa       <= sel_addr;
                        wdata    <= sel_data;
                        we       <= (sel_addr != 5'd0);
                        grant_id <= xfer1;
                        prio     <= xfer0;
                    end else begin
                        we <= 1'b0;
                    end
                end
                CLEAR: begin
                    wa       <= cnt;
                    wdata    <= '0;
                    we       <= 1'b1;
                    grant_id <= 1'b0;
                    if (cnt == 5'd31) begin
                        state    <= RUN;
                        cnt      <= 5'd1;
                        clr_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: doc/regwr_sched.md
REGWR_SCHED -- requirements
Module: regwr_sched

Interface
REQ-001 SHALL have parameter DW, default 32, register data width.
REQ-002 SHALL have parameter PRIO_INIT, default 0, requester holding priority after reset.
REQ-003 SHALL have port ck, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port clr_req, input, 1, request to zero registers 1..31.
REQ-006 SHALL have port req0_valid, input, 1, requester 0 write pending.
REQ-007 SHALL have port req0_addr, input, 5, requester 0 destination register.
REQ-008 SHALL have port req0_data, input, DW, requester 0 write data.
REQ-009 SHALL have port req0_ready, output, 1, requester 0 accepted this cycle.
REQ-010 SHALL have ports req1_valid, req1_addr, req1_data and req1_ready, identical to requester 0.
REQ-011 SHALL have port wa, output, 5, register file write address.
REQ-012 SHALL have port wdata, output, DW, register file write data.
REQ-013 SHALL have port we, output, 1, register file write enable.
REQ-014 SHALL have port grant_id, output, 1, requester that produced the current write (0 during clear).
REQ-015 SHALL have port clr_busy, output, 1, clear sequence in progress.

Function
REQ-016 SHALL implement FSM states RUN and CLEAR.
REQ-017 SHALL drive wa, wdata, we, grant_id and clr_busy from registers.
REQ-018 SHALL drive reqN_ready combinationally, only in RUN, with at most one ready high per cycle.
REQ-019 SHALL complete a transfer when valid and ready are both high at a rising edge.
REQ-020 SHALL, in RUN with a single requester valid and clr_req low, assert that requester's ready.
REQ-021 SHALL, in RUN with both requesters valid and clr_req low, grant the requester indicated by the priority pointer.
REQ-022 SHALL, after every completed transfer, set the priority pointer to the requester that was not granted.
REQ-023 SHALL leave the priority pointer unchanged in cycles with no transfer.
REQ-024 SHALL, on the edge after a transfer, present wa=addr, wdata=data, grant_id=granted requester and we=1 (one-cycle latency).
REQ-025 SHALL accept a transfer with addr=0 (ready high) but drive we=0 on the following cycle; wa and wdata may still update.
REQ-026 SHALL drive we=0 in any cycle that does not follow a transfer or a clear step.
REQ-027 SHALL, when clr_req is high in RUN, hold both ready signals low that cycle and enter CLEAR on the next edge; clear takes precedence over requests.
REQ-028 SHALL, in CLEAR, step a 5-bit counter 1..31, one per cycle, each step producing wa=counter, wdata=0, we=1, grant_id=0 on the following edge.
REQ-029 SHALL assert clr_busy from the CLEAR entry edge through the edge that outputs the wa=31 write, and return to RUN after the count 31 step.
REQ-030 SHALL ignore clr_req while in CLEAR.
REQ-031 SHALL keep requester data held externally during CLEAR, with no request dropped or reordered; each requester resumes arbitration in RUN.
REQ-032 SHALL not wrap the counter: a clear is exactly 31 writes.

Reset
REQ-033 SHALL, while reset is low, force FSM=RUN, counter=1, priority pointer=PRIO_INIT, we=0, wa=0, wdata=0, grant_id=0, clr_busy=0, both ready=0.
REQ-034 SHALL, when reset asserts mid-CLEAR, abort the sequence with no further clear writes after release.
REQ-035 SHALL accept requests on the first edge after reset deasserts.

Verification
REQ-036 Single requester: req0 valid, addr=5, data=0xDEADBEEF -> req0_ready=1 same cycle; next cycle we=1, wa=5, wdata=0xDEADBEEF, grant_id=0.
REQ-037 Contention: both valid for 4 cycles (addr 3 and 4), PRIO_INIT=0 -> grants 0,1,0,1; we=1 on each following cycle.
REQ-038 r0 discard: req1 addr=0, data=0x1234 -> req1_ready=1; next cycle we=0.
REQ-039 Clear: pulse clr_req with req0 valid -> req0_ready=0; 31 consecutive writes wa=1..31, wdata=0; clr_busy high for 31 cycles; then the pending req0 is accepted.
REQ-040 Reset mid-clear: assert reset after wa=10 is output -> we=0 immediately; after release FSM=RUN with no further clear writes.
REQ-041 clr_req during CLEAR: second pulse at step 15 -> sequence still ends at wa=31 with no restart.
